// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the image-RAM arbiter.
// Build option: RAM_ARB_FIXED_PRIO_EN selects fixed priority instead of bounded round-robin.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_0    = 2'd1,
      OWN_1    = 2'd2
   } owner_t;

   localparam int DEF_ADDR_W = 12;
   localparam int DEF_DATA_W = 8;

   // Counter must hold the value MAX_BURST itself.
   function automatic int cnt_w(input int max_burst);
      return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Pure grant decision for the two-requester RAM arbiter.
// Build option: RAM_ARB_FIXED_PRIO_EN makes requester 0 win every contended cycle.
module ram_arb_pick
   import ram_arb_pkg::*;
#(
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = cnt_w(MAX_BURST)
) (
   input  logic             req0,
   input  logic             req1,
   input  owner_t           owner,
   input  logic [CNT_W-1:0] burst_cnt,
   input  logic             rr_next,
   output logic [1:0]       gnt
);

   always_comb begin
      gnt = 2'b00;
      if (req0 && !req1) begin
         gnt = 2'b01;
      end else if (req1 && !req0) begin
         gnt = 2'b10;
      end else if (req0 && req1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
         gnt = 2'b01;
`else
         // Owner keeps the RAM until its burst is spent, then hands over.
         if (owner == OWN_0 && burst_cnt < CNT_W'(MAX_BURST))
            gnt = 2'b01;
         else if (owner == OWN_1 && burst_cnt < CNT_W'(MAX_BURST))
            gnt = 2'b10;
         else if (owner == OWN_0)
            gnt = 2'b10;
         else if (owner == OWN_1)
            gnt = 2'b01;
         else
            gnt = rr_next ? 2'b10 : 2'b01;
`endif
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter sharing the single-port image RAM between the convolution core (0) and loader (1).
// Build option: RAM_ARB_FIXED_PRIO_EN (see ram_arb_pick).
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              ram_w_en,
   output logic              ram_r_en,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data_in,
   input  logic [DATA_W-1:0] ram_data_out
);

   localparam int CNT_W = cnt_w(MAX_BURST);

   owner_t           owner;
   logic [CNT_W-1:0] burst_cnt;
   logic             rr_next;
   logic             rd_vld;
   logic             rd_id;
   logic [1:0]       pick;
   logic [1:0]       gnt;

   ram_arb_pick #(.MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) u_pick (
      .req0      (req0),
      .req1      (req1),
      .owner     (owner),
      .burst_cnt (burst_cnt),
      .rr_next   (rr_next),
      .gnt       (pick)
   );

   assign gnt  = rst ? 2'b00 : pick;
   assign gnt0 = gnt[0];
   assign gnt1 = gnt[1];

   always_comb begin
      ram_w_en    = 1'b0;
      ram_r_en    = 1'b0;
      ram_address = '0;
      ram_data_in = '0;
      if (gnt[0]) begin
         ram_w_en    = we0;
         ram_r_en    = !we0;
         ram_address = addr0;
         ram_data_in = wdata0;
      end else if (gnt[1]) begin
         ram_w_en    = we1;
         ram_r_en    = !we1;
         ram_address = addr1;
         ram_data_in = wdata1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner     <= OWN_NONE;
         burst_cnt <= '0;
         rr_next   <= 1'b0;
         rd_vld    <= 1'b0;
         rd_id     <= 1'b0;
      end else begin
         rd_vld <= ram_r_en;
         rd_id  <= gnt[1];
         if (gnt[0]) begin
            if (owner == OWN_0) begin
               if (burst_cnt < CNT_W'(MAX_BURST))
                  burst_cnt <= burst_cnt + CNT_W'(1);
            end else begin
               owner     <= OWN_0;
               burst_cnt <= CNT_W'(1);
            end
            rr_next <= 1'b1;
         end else if (gnt[1]) begin
            if (owner == OWN_1) begin
               if (burst_cnt < CNT_W'(MAX_BURST))
                  burst_cnt <= burst_cnt + CNT_W'(1);
            end else begin
               owner     <= OWN_1;
               burst_cnt <= CNT_W'(1);
            end
            rr_next <= 1'b0;
         end else begin
            owner <= OWN_NONE;
         end
      end
   end

   // Read data is owned by whoever was granted the read one cycle earlier.
   assign rvalid0 = rd_vld && !rd_id;
   assign rvalid1 = rd_vld && rd_id;
   assign rdata0  = rvalid0 ? ram_data_out : '0;
   assign rdata1  = rvalid1 ? ram_data_out : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural 4096x8 sync-read RAM.
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, we0, req1, we1;
   logic [11:0] addr0, addr1;
   logic [7:0]  wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [7:0]  rdata0, rdata1;
   logic        ram_w_en, ram_r_en;
   logic [11:0] ram_address;
   logic [7:0]  ram_data_in, ram_data_out;

   logic [7:0]  mem [0:4095];
   logic [7:0]  q0[$], q1[$];
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   ram_arbiter dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1),
      .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .ram_w_en(ram_w_en), .ram_r_en(ram_r_en),
      .ram_address(ram_address), .ram_data_in(ram_data_in),
      .ram_data_out(ram_data_out)
   );

   always @(posedge clk) begin
      if (ram_w_en) mem[ram_address] <= ram_data_in;
      if (ram_r_en) ram_data_out <= mem[ram_address];
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [7:0] e;
      rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
      addr0 = 12'h000; addr1 = 12'h001;
      @(negedge clk);
      n_chk++;
      if ({gnt0, gnt1, ram_w_en, ram_r_en} !== 4'b0000 || ram_address !== 12'h0 || ram_data_in !== 8'h0) begin
         n_fail++;
         $display("FAIL reset_outputs got gnt=%b%b w=%b r=%b a=%h d=%h required all 0",
                  gnt0, gnt1, ram_w_en, ram_r_en, ram_address, ram_data_in);
      end
      next_cycle();
      @(negedge clk);
      n_chk++;
      if ({rvalid0, rvalid1, gnt0, gnt1} !== 4'b0000 || rdata0 !== 8'h0 || rdata1 !== 8'h0) begin
         n_fail++;
         $display("FAIL reset_rvalid got rv=%b%b gnt=%b%b rd=%h/%h required 0",
                  rvalid0, rvalid1, gnt0, gnt1, rdata0, rdata1);
      end
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_first_grant got gnt0=%b gnt1=%b required 1 0", gnt0, gnt1);
      end
      q0.push_back(8'h5C);
      next_cycle();
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      e = q0.pop_front();
      n_chk++;
      if (rvalid0 !== 1'b1 || rdata0 !== e || rvalid1 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_first_read got rv0=%b rd0=%h rv1=%b required 1 %h 0", rvalid0, rdata0, rvalid1, e);
      end
      next_cycle();
   endtask

   task automatic test_single_read();
      logic [7:0] e;
      req0 = 1'b1; we0 = 1'b0; addr0 = 12'h008;
      q0.push_back(8'hFF);
      @(negedge clk);
      n_chk++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || ram_r_en !== 1'b1 || ram_w_en !== 1'b0 || ram_address !== 12'h008) begin
         n_fail++;
         $display("FAIL single_read_cmd got gnt=%b%b r=%b w=%b a=%h required 10 1 0 008",
                  gnt0, gnt1, ram_r_en, ram_w_en, ram_address);
      end
      next_cycle();
      req0 = 1'b0;
      @(negedge clk);
      e = q0.pop_front();
      n_chk++;
      if (rvalid0 !== 1'b1 || rdata0 !== e || rvalid1 !== 1'b0 || rdata1 !== 8'h0) begin
         n_fail++;
         $display("FAIL single_read_data got rv0=%b rd0=%h rv1=%b rd1=%h required 1 %h 0 00",
                  rvalid0, rdata0, rvalid1, rdata1, e);
      end
      next_cycle();
   endtask

   task automatic test_write_read();
      logic [7:0] e;
      req1 = 1'b1; we1 = 1'b1; addr1 = 12'h100; wdata1 = 8'hA5;
      @(negedge clk);
      n_chk++;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || ram_w_en !== 1'b1 || ram_r_en !== 1'b0 ||
          ram_address !== 12'h100 || ram_data_in !== 8'hA5) begin
         n_fail++;
         $display("FAIL write_cmd got gnt=%b%b w=%b r=%b a=%h d=%h required 01 1 0 100 a5",
                  gnt0, gnt1, ram_w_en, ram_r_en, ram_address, ram_data_in);
      end
      next_cycle();
      we1 = 1'b0;
      q1.push_back(8'hA5);
      @(negedge clk);
      n_chk++;
      if (gnt1 !== 1'b1 || ram_r_en !== 1'b1 || rvalid1 !== 1'b0 || rvalid0 !== 1'b0) begin
         n_fail++;
         $display("FAIL read_after_write_cmd got gnt1=%b r=%b rv1=%b rv0=%b required 1 1 0 0",
                  gnt1, ram_r_en, rvalid1, rvalid0);
      end
      next_cycle();
      req1 = 1'b0;
      @(negedge clk);
      e = q1.pop_front();
      n_chk++;
      if (rvalid1 !== 1'b1 || rdata1 !== e || rvalid0 !== 1'b0) begin
         n_fail++;
         $display("FAIL read_after_write_data got rv1=%b rd1=%h rv0=%b required 1 %h 0", rvalid1, rdata1, rvalid0, e);
      end
      next_cycle();
   endtask

   task automatic test_fairness();
      logic p0, p1, e0;
      logic [7:0] e;
      p0 = 1'b0; p1 = 1'b0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 12'h020;
      req1 = 1'b1; we1 = 1'b0; addr1 = 12'h030;
      for (int i = 0; i < 13; i++) begin
         if (i == 12) begin
            req0 = 1'b0; req1 = 1'b0;
         end
         @(negedge clk);
`ifdef RAM_ARB_FIXED_PRIO_EN
         e0 = 1'b1;
`else
         e0 = ((i / 4) % 2) == 0;
`endif
         if (i < 12) begin
            n_chk++;
            if (gnt0 !== e0 || gnt1 !== !e0) begin
               n_fail++;
               $display("FAIL fairness_gnt[%0d] got gnt0=%b gnt1=%b required %b %b", i, gnt0, gnt1, e0, !e0);
            end
         end
         n_chk++;
         if (rvalid0 !== p0 || rvalid1 !== p1) begin
            n_fail++;
            $display("FAIL fairness_rvalid[%0d] got %b%b required %b%b", i, rvalid0, rvalid1, p0, p1);
         end
         if (p0 && q0.size() > 0) begin
            e = q0.pop_front();
            n_chk++;
            if (rdata0 !== e) begin
               n_fail++;
               $display("FAIL fairness_rdata0[%0d] got %h required %h", i, rdata0, e);
            end
         end
         if (p1 && q1.size() > 0) begin
            e = q1.pop_front();
            n_chk++;
            if (rdata1 !== e) begin
               n_fail++;
               $display("FAIL fairness_rdata1[%0d] got %h required %h", i, rdata1, e);
            end
         end
         if (i < 12) begin
            if (e0) q0.push_back(8'h11);
            else    q1.push_back(8'h22);
            p0 = e0; p1 = !e0;
         end
         next_cycle();
      end
   endtask

   task automatic test_burst_early_end();
      logic e0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 12'h020;
      req1 = 1'b0; we1 = 1'b0; addr1 = 12'h030;
      for (int i = 0; i < 6; i++) begin
         if (i == 2) req1 = 1'b1;
         @(negedge clk);
`ifdef RAM_ARB_FIXED_PRIO_EN
         e0 = 1'b1;
`else
         e0 = (i < 4);
`endif
         n_chk++;
         if (gnt0 !== e0 || gnt1 !== !e0) begin
            n_fail++;
            $display("FAIL burst_early_end[%0d] got gnt0=%b gnt1=%b required %b %b", i, gnt0, gnt1, e0, !e0);
         end
         next_cycle();
      end
      req0 = 1'b0; req1 = 1'b0;
      next_cycle();
   endtask

   task automatic test_reset_mid_burst();
      logic [7:0] e;
      q0.delete(); q1.delete();
      req0 = 1'b1; we0 = 1'b0; addr0 = 12'h020;
      req1 = 1'b1; we1 = 1'b0; addr1 = 12'h030;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_chk++;
         if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_burst_gnt[%0d] got gnt0=%b gnt1=%b required 1 0", i, gnt0, gnt1);
         end
         q0.push_back(8'h11);
         next_cycle();
      end
      rst = 1'b1;
      @(negedge clk);
      void'(q0.pop_front());
      e = q0.pop_front();
      n_chk++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || ram_r_en !== 1'b0 || rvalid0 !== 1'b1 || rdata0 !== e) begin
         n_fail++;
         $display("FAIL mid_burst_rst got gnt=%b%b r=%b rv0=%b rd0=%h required 00 0 1 %h",
                  gnt0, gnt1, ram_r_en, rvalid0, rdata0, e);
      end
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
         n_fail++;
         $display("FAIL after_rst got gnt=%b%b rv=%b%b required 10 00", gnt0, gnt1, rvalid0, rvalid1);
      end
      next_cycle();
      req0 = 1'b0; req1 = 1'b0;
      next_cycle();
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      mem[12'h000] = 8'h5C;
      mem[12'h008] = 8'hFF;
      mem[12'h020] = 8'h11;
      mem[12'h030] = 8'h22;
      ram_data_out = 8'h00;
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      next_cycle();
      test_reset();
      test_single_read();
      test_write_read();
      test_fairness();
      test_burst_early_end();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter that shares the single-port 4096 x 8 image RAM between the convolution core (requester 0) and the image loader/readout path (requester 1). At most one access per cycle reaches the RAM. Arbitration is round-robin with a bounded burst, so a requester can stream pixels without starving the other. Read data returns one cycle after grant, tagged to its owner. The block sits directly in front of the RAM's `w_en`/`r_en`/`address`/`data_in`/`data_out` pins.

## Interface
- `ADDR_W`, 12, RAM address width
- `DATA_W`, 8, pixel width
- `MAX_BURST`, 4, max consecutive grants to one requester while the other waits (>= 1)

- `clk`  in  1  sole clock, all state on posedge
- `rst`  in  1  synchronous, active-high reset
- `req0`/`req1`  in  1  access request, held until granted
- `we0`/`we1`  in  1  1 = write, 0 = read
- `addr0`/`addr1`  in  ADDR_W  access address
- `wdata0`/`wdata1`  in  DATA_W  write data
- `gnt0`/`gnt1`  out  1  access issued this cycle (combinational)
- `rvalid0`/`rvalid1`  out  1  read data valid (registered)
- `rdata0`/`rdata1`  out  DATA_W  `ram_data_out` when own `rvalid` is high, else 0
- `ram_w_en`, `ram_r_en`  out  1  RAM strobes
- `ram_address`  out  ADDR_W  muxed address
- `ram_data_in`  out  DATA_W  muxed write data
- `ram_data_out`  in  DATA_W  RAM sync read data (1-cycle latency)

## Operation
- State: `owner` (NONE/0/1), `burst_cnt` (width of `MAX_BURST`, counts 1..`MAX_BURST`), `rr_next` (0/1), `rd_tag` (rvalid pipeline: valid bit plus requester id).
- Grant decision each cycle (not in `rst`):
  - Neither request: no grant. `owner` becomes NONE.
  - One request: grant it.
  - Both, `owner` = X, `burst_cnt` < `MAX_BURST`: grant X.
  - Both, otherwise: grant the non-owner. With `owner` = NONE, grant `rr_next`.
- Exactly one of `gnt0`/`gnt1` is high per cycle, or neither.
- On a grant to X:
  - If `owner` == X: `burst_cnt`++ (saturates at `MAX_BURST`).
  - Else: `owner` = X and `burst_cnt` = 1.
  - `rr_next` is set to the other requester.
- `ram_w_en` = grant & `we`; `ram_r_en` = grant & !`we`. `ram_address`/`ram_data_in` carry the granted requester's values, else 0.
- A granted read sets `rd_tag` = {1, X} at the edge. `rvalidX` is high for the following cycle only. Writes never raise `rvalid`.
- Requesters keep `we`/`addr`/`wdata` stable while `req` is high and not granted. Changing them during a wait is illegal.
- A request is consumed by its grant. A requester wanting another access keeps `req` high next cycle (back-to-back access allowed).
- Dropping `req` ends that requester's burst at the next edge.

## Timing
- Cycle N: `req`&`gnt` high, RAM command driven combinationally in N. RAM samples at end of N.
- Cycle N+1: `rvalidX` = 1, `rdataX` = `ram_data_out`.
- Throughput: 1 access/cycle. Worst-case wait for a requesting port is `MAX_BURST` cycles.
- While `rst` is high: `gnt*`, `ram_w_en`, `ram_r_en` = 0; `ram_address`, `ram_data_in` = 0.
- First edge with `rst` high: `owner` = NONE, `burst_cnt` = 0, `rr_next` = 0, `rd_tag` cleared.
- Cycle after that edge: `rvalid*` = 0, `rdata*` = 0.
- Reset mid-burst: the burst is abandoned. A read granted in the cycle before `rst` rises still returns `rvalid` in the `rst` cycle. No read is granted while `rst` is high.
- Simultaneous first requests after reset: requester 0 wins.

## Configuration
- `RAM_ARB_FIXED_PRIO_EN` defined: when both request, requester 0 always wins. `burst_cnt`/`rr_next` are unused and requester 1 may starve.
- Undefined: round-robin with `MAX_BURST` as above.

## Structure
- Shared package `ram_arb_pkg`:
  - owner enum `OWN_NONE`/`OWN_0`/`OWN_1`
  - default `ADDR_W`/`DATA_W` constants
  - `burst_cnt` width function
- One sub-module `ram_arb_pick`: pure decision logic taking requests, `owner`, `burst_cnt` and `rr_next` and returning the grant vector. The top level holds the registers and the datapath muxes.

## Test plan
- Reset: assert `rst` with `req0`=`req1`=1 → `gnt*` = 0, no RAM strobes. The first cycle after release grants 0.
- Single read: `req0`, `we0`=0, `addr0`=12'h008 with RAM[8]=8'hFF → `gnt0` in N, `rvalid0`=1 and `rdata0`=8'hFF in N+1, `rvalid1`=0.
- Write then read: `req1` writes 8'hA5 to 12'h100, then reads 12'h100 → `rdata1`=8'hA5 one cycle after the second grant.
- Burst fairness (`MAX_BURST`=4): both held high continuously → grant pattern 0,0,0,0,1,1,1,1,0...
- Burst early end: `req0` alone for 2 grants, then both request → 0 continues to a total of 4 grants, then 1.
- Reset mid-burst: `rst` after the 2nd grant of a burst with reads in flight → the read from the cycle before `rst` returns `rvalid`. After reset, `owner` = NONE and both requesting → 0 granted.
- Macro on: repeat the fairness test → `gnt0` every cycle, `gnt1` never.
